// File: rtl/vec_cmd_sequencer_pkg.sv
// Package: vec_seq_pkg
// Shared types for the vector command sequencer: opcode and FSM state enums,
// the queued command struct and the core register-file geometry.
// The core geometry (els_p, vlen_p, vdw_p) lives here because cmd_s is a
// packed struct and needs fixed field widths.
package vec_seq_pkg;

  localparam int els_p     = 8;   // vectors in the core register file
  localparam int vlen_p    = 4;   // elements per vector
  localparam int vdw_p     = 4;   // bits per element
  localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int data_w_lp = vlen_p * vdw_p;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_ADDS  = 4'b0100,
    OP_READ  = 4'b1000,
    OP_WRITE = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [addr_w_lp-1:0] addrA;
    logic [addr_w_lp-1:0] addrB;
    logic [addr_w_lp-1:0] addrC;
    logic [data_w_lp-1:0] scalar;
    logic [data_w_lp-1:0] wdata;
  } cmd_s;

  // True for the four opcodes the core understands.
  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDS) || (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/vec_cmd_sequencer_if.sv
// Interface: vec_cmd_sequencer_if
// Bundles the host command port, the core issue/done port and the host
// result port of vec_cmd_sequencer. Signal suffixes are from the
// sequencer's point of view.
//   slave  : the sequencer (consumes cmd_*, drives core_*_o / res_*_o / err_o)
//   master : host + core environment
interface vec_cmd_sequencer_if;
  import vec_seq_pkg::*;

  // host command port
  logic                 cmd_v_i;
  logic                 cmd_ready_o;
  logic [3:0]           cmd_op_i;
  logic [addr_w_lp-1:0] cmd_addrA_i;
  logic [addr_w_lp-1:0] cmd_addrB_i;
  logic [addr_w_lp-1:0] cmd_addrC_i;
  logic [data_w_lp-1:0] cmd_scalar_i;
  logic [data_w_lp-1:0] cmd_wdata_i;
  // core port
  logic                 core_v_o;
  logic                 core_ready_i;
  logic [3:0]           core_op_o;
  logic [addr_w_lp-1:0] core_addrA_o;
  logic [addr_w_lp-1:0] core_addrB_o;
  logic [addr_w_lp-1:0] core_addrC_o;
  logic [data_w_lp-1:0] core_scalar_o;
  logic [data_w_lp-1:0] core_wdata_o;
  logic                 core_done_i;
  logic [data_w_lp-1:0] core_rdata_i;
  logic                 core_yumi_o;
  // host result port
  logic                 res_v_o;
  logic [data_w_lp-1:0] res_data_o;
  logic                 res_yumi_i;
  logic                 err_o;

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
           cmd_scalar_i, cmd_wdata_i, core_ready_i, core_done_i,
           core_rdata_i, res_yumi_i,
    output cmd_ready_o, core_v_o, core_op_o, core_addrA_o, core_addrB_o,
           core_addrC_o, core_scalar_o, core_wdata_o, core_yumi_o,
           res_v_o, res_data_o, err_o
  );

  modport master (
    output cmd_v_i, cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrC_i,
           cmd_scalar_i, cmd_wdata_i, core_ready_i, core_done_i,
           core_rdata_i, res_yumi_i,
    input  cmd_ready_o, core_v_o, core_op_o, core_addrA_o, core_addrB_o,
           core_addrC_o, core_scalar_o, core_wdata_o, core_yumi_o,
           res_v_o, res_data_o, err_o
  );

endinterface

// File: rtl/vec_cmd_sequencer_fifo.sv
// Module: vec_seq_fifo
// 1-read/1-write circular FIFO, v/ready on the input, v/yumi on the output.
// No bypass: a written entry shows at the head the cycle after the write.
// ready_o is simply "not full", so a full FIFO refuses writes even in a
// cycle where the head is being dequeued.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   v_i/ready_o      write handshake, data_i write data
//   v_o/data_o       head valid / head data (data_o is 0 while empty)
//   yumi_i           consume head; only honoured while v_o=1
module vec_seq_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic                enq, deq;

  assign ready_o = (cnt_q != full_lp);
  assign v_o     = (cnt_q != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = v_o ? mem_q[rptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) wptr_q <= (wptr_q == last_lp) ? '0 : wptr_q + ptr_w_lp'(1);
      if (deq) rptr_q <= (rptr_q == last_lp) ? '0 : rptr_q + ptr_w_lp'(1);
      cnt_q <= cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/vec_cmd_sequencer.sv
// Module: vec_cmd_sequencer
// Buffered command front-end for the vector accelerator core. Host commands
// (write/read/add/add-scalar) are queued, issued in order over the core's
// v/ready/done handshake, and read data comes back through a result FIFO.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset (shared with core)
//   bus (slave)      cmd_* host command port, core_* issue/done port,
//                    res_* result port, err_o sticky illegal-opcode flag
// Optional build macro VEC_SEQ_PERF_EN adds 32-bit wrapping counters
//   perf_busy_o  cycles not in IDLE
//   perf_stall_o cycles in ISSUE with core_ready_i low
//   perf_cmds_o  commands completed by the core
module vec_cmd_sequencer
  import vec_seq_pkg::*;
#(
  parameter int cmd_els_p = 4,  // command FIFO depth, >=2, power of 2
  parameter int res_els_p = 2   // result FIFO depth = max outstanding reads
) (
  input  logic clk_i,
  input  logic reset_i,
  vec_cmd_sequencer_if.slave bus
`ifdef VEC_SEQ_PERF_EN
  , output logic [31:0] perf_busy_o
  , output logic [31:0] perf_stall_o
  , output logic [31:0] perf_cmds_o
`endif
);
  localparam int cred_w_lp = $clog2(res_els_p + 1);
  localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(res_els_p);

  state_e                  state_q;
  cmd_s                    cmd_in, cmd_head, core_cmd_q;
  logic [$bits(cmd_s)-1:0] cmd_head_raw;
  logic                    cmd_head_v, cmd_deq;
  op_e                     op_q;
  logic                    core_v_q, core_yumi_q, err_q;
  logic [cred_w_lp-1:0]    credits_q, credits_d;
  logic                    head_legal, credit_ok, head_elig;
  logic                    accept, drop, done, cred_dec, cred_inc;
  logic                    res_push, res_space;

  // ---------------- command FIFO ----------------
  assign cmd_in.op     = op_e'(bus.cmd_op_i);
  assign cmd_in.addrA  = bus.cmd_addrA_i;
  assign cmd_in.addrB  = bus.cmd_addrB_i;
  assign cmd_in.addrC  = bus.cmd_addrC_i;
  assign cmd_in.scalar = bus.cmd_scalar_i;
  assign cmd_in.wdata  = bus.cmd_wdata_i;

  vec_seq_fifo #(.width_p($bits(cmd_s)), .els_p(cmd_els_p)) u_cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (bus.cmd_v_i),
    .ready_o (bus.cmd_ready_o),
    .data_i  (cmd_in),
    .v_o     (cmd_head_v),
    .data_o  (cmd_head_raw),
    .yumi_i  (cmd_deq)
  );
  assign cmd_head = cmd_head_raw;

  // ---------------- issue control ----------------
  // A result being consumed this cycle frees a credit in time for a READ
  // waiting at the head, so the read issues the very next cycle.
  assign head_legal = op_legal(cmd_head.op);
  assign credit_ok  = (credits_q != '0) | cred_inc;
  assign head_elig  = cmd_head_v & head_legal & ((cmd_head.op != OP_READ) | credit_ok);

  assign accept   = (state_q == ISSUE) & bus.core_ready_i;
  assign drop     = (state_q == IDLE) & cmd_head_v & ~head_legal;
  assign done     = (state_q == WAIT_DONE) & bus.core_done_i;
  assign cmd_deq  = accept | drop;
  assign cred_dec = accept & (core_cmd_q.op == OP_READ);
  assign cred_inc = bus.res_yumi_i & bus.res_v_o;
  assign res_push = done & (op_q == OP_READ);

  always_comb begin
    credits_d = credits_q;
    if (cred_dec && !cred_inc)
      credits_d = credits_q - cred_w_lp'(1);
    else if (cred_inc && !cred_dec && credits_q != cred_max_lp)
      credits_d = credits_q + cred_w_lp'(1);
  end

  // FSM with registered core-side outputs. core_cmd_q is a copy of the
  // head taken when entering ISSUE; it is held until the core accepts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      core_v_q    <= 1'b0;
      core_cmd_q  <= '0;
      op_q        <= OP_ADD;
      core_yumi_q <= 1'b0;
      credits_q   <= cred_max_lp;
      err_q       <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (drop) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (head_elig) begin
            state_q    <= ISSUE;
            core_v_q   <= 1'b1;
            core_cmd_q <= cmd_head;
          end
        end
        ISSUE: begin
          if (bus.core_ready_i) begin
            state_q     <= WAIT_DONE;
            core_v_q    <= 1'b0;
            core_cmd_q  <= '0;
            op_q        <= core_cmd_q.op;
            core_yumi_q <= (core_cmd_q.op == OP_READ);
          end
        end
        WAIT_DONE: begin
          if (bus.core_done_i) begin
            core_yumi_q <= 1'b0;
            // the head already holds the next command: issue back-to-back
            if (head_elig) begin
              state_q    <= ISSUE;
              core_v_q   <= 1'b1;
              core_cmd_q <= cmd_head;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.core_v_o      = core_v_q;
  assign bus.core_op_o     = core_cmd_q.op;
  assign bus.core_addrA_o  = core_cmd_q.addrA;
  assign bus.core_addrB_o  = core_cmd_q.addrB;
  assign bus.core_addrC_o  = core_cmd_q.addrC;
  assign bus.core_scalar_o = core_cmd_q.scalar;
  assign bus.core_wdata_o  = core_cmd_q.wdata;
  assign bus.core_yumi_o   = core_yumi_q;
  assign bus.err_o         = err_q;

  // ---------------- result FIFO ----------------
  // Credits bound outstanding reads plus stored results, so a push always
  // finds space.
  vec_seq_fifo #(.width_p(data_w_lp), .els_p(res_els_p)) u_res_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (res_push),
    .ready_o (res_space),
    .data_i  (bus.core_rdata_i),
    .v_o     (bus.res_v_o),
    .data_o  (bus.res_data_o),
    .yumi_i  (bus.res_yumi_i)
  );

  assert property (@(posedge clk_i) disable iff (reset_i) res_push |-> res_space);

`ifdef VEC_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q, perf_cmds_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
      perf_cmds_q  <= '0;
    end else begin
      if (state_q != IDLE)                         perf_busy_q  <= perf_busy_q + 32'd1;
      if (state_q == ISSUE && !bus.core_ready_i)   perf_stall_q <= perf_stall_q + 32'd1;
      if (done)                                    perf_cmds_q  <= perf_cmds_q + 32'd1;
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
  assign perf_cmds_o  = perf_cmds_q;
`endif

endmodule
